// File: rtl/aes_round_sequencer_if.sv
// Bundles the sequencer's host handshake and its four step-unit links.
// The master modport is the sequencer; the slave modport is the host plus step units.
interface aes_round_sequencer_if;
    localparam int unsigned DATA_W = 128;
    localparam int unsigned RND_W  = 4;

    // host side
    logic              start;
    logic [DATA_W-1:0] plaintext;
    logic [DATA_W-1:0] state_out;
    logic [RND_W-1:0]  roundnumber;
    logic              busy;
    logic              done;
    logic              error;

    // step-unit side
    logic              ark_start;
    logic              sb_start;
    logic              sr_start;
    logic              mc_start;
    logic              ark_finish;
    logic              sb_finish;
    logic              sr_finish;
    logic              mc_finish;
    logic [DATA_W-1:0] ark_result;
    logic [DATA_W-1:0] sb_result;
    logic [DATA_W-1:0] sr_result;
    logic [DATA_W-1:0] mc_result;

    modport master (
        input  start, plaintext,
        input  ark_finish, sb_finish, sr_finish, mc_finish,
        input  ark_result, sb_result, sr_result, mc_result,
        output state_out, roundnumber, busy, done, error,
        output ark_start, sb_start, sr_start, mc_start
    );

    modport slave (
        output start, plaintext,
        output ark_finish, sb_finish, sr_finish, mc_finish,
        output ark_result, sb_result, sr_result, mc_result,
        input  state_out, roundnumber, busy, done, error,
        input  ark_start, sb_start, sr_start, mc_start
    );
endinterface

// File: rtl/aes_round_sequencer.sv
// AES-128 round sequencer: walks the 40-step SB/SR/MC/ARK schedule over
// external step units, owning the state register and the round counter.
module aes_round_sequencer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    aes_round_sequencer_if.master  bus
);
    localparam int unsigned DATA_W     = 128;
    localparam int unsigned RND_W      = 4;
    localparam int unsigned LAST_ROUND = 10;
    localparam int unsigned CNT_W      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        IDLE,
        SB_ISSUE,
        SB_WAIT,
        SR_ISSUE,
        SR_WAIT,
        MC_ISSUE,
        MC_WAIT,
        ARK_ISSUE,
        ARK_WAIT,
        DONE,
        ERR
    } state_t;

    state_t             state_q;
    state_t             state_nx;
    logic [DATA_W-1:0]  state_out_q;
    logic [RND_W-1:0]   round_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               ark_start_q;
    logic               sb_start_q;
    logic               sr_start_q;
    logic               mc_start_q;
    logic               busy_q;
    logic               done_q;
    logic               error_q;

    logic               load_pt_c;
    logic               load_res_c;
    logic [DATA_W-1:0]  result_c;
    logic               round_inc_c;
    logic               cnt_clr_c;
    logic               cnt_inc_c;
    logic               fin_c;
    logic               last_round_c;
    logic               timeout_c;
    logic               busy_nx_c;

    assign last_round_c = (round_q == RND_W'(LAST_ROUND));
    assign timeout_c    = (cnt_q == CNT_W'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nx;
        end
    end

    // Next-state decode: only the active unit's finish is looked at, and only in WAIT.
    always_comb begin
        state_nx    = state_q;
        load_pt_c   = 1'b0;
        load_res_c  = 1'b0;
        result_c    = '0;
        round_inc_c = 1'b0;
        cnt_clr_c   = 1'b0;
        cnt_inc_c   = 1'b0;
        fin_c       = 1'b0;

        case (state_q)
            IDLE, DONE, ERR: begin
                if (bus.start) begin
                    state_nx  = ARK_ISSUE;
                    load_pt_c = 1'b1;
                end
            end
            SB_ISSUE: begin
                state_nx  = SB_WAIT;
                cnt_clr_c = 1'b1;
            end
            SR_ISSUE: begin
                state_nx  = SR_WAIT;
                cnt_clr_c = 1'b1;
            end
            MC_ISSUE: begin
                state_nx  = MC_WAIT;
                cnt_clr_c = 1'b1;
            end
            ARK_ISSUE: begin
                state_nx  = ARK_WAIT;
                cnt_clr_c = 1'b1;
            end
            SB_WAIT: begin
                fin_c    = bus.sb_finish;
                result_c = bus.sb_result;
                if (fin_c) begin
                    state_nx = SR_ISSUE;
                end
            end
            SR_WAIT: begin
                fin_c    = bus.sr_finish;
                result_c = bus.sr_result;
                if (fin_c) begin
                    // the final round skips MixColumns
                    state_nx = last_round_c ? ARK_ISSUE : MC_ISSUE;
                end
            end
            MC_WAIT: begin
                fin_c    = bus.mc_finish;
                result_c = bus.mc_result;
                if (fin_c) begin
                    state_nx = ARK_ISSUE;
                end
            end
            ARK_WAIT: begin
                fin_c    = bus.ark_finish;
                result_c = bus.ark_result;
                if (fin_c) begin
                    if (last_round_c) begin
                        state_nx = DONE;
                    end else begin
                        state_nx    = SB_ISSUE;
                        round_inc_c = 1'b1;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        // shared WAIT handling: capture on finish, otherwise age the wait counter
        if (state_q == SB_WAIT || state_q == SR_WAIT ||
            state_q == MC_WAIT || state_q == ARK_WAIT) begin
            if (fin_c) begin
                load_res_c = 1'b1;
            end else if (timeout_c) begin
                state_nx = ERR;
            end else begin
                cnt_inc_c = 1'b1;
            end
        end
    end

    assign busy_nx_c = (state_nx != IDLE) && (state_nx != DONE) && (state_nx != ERR);

    // Registered outputs, decoded from the upcoming state so they align with it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ark_start_q <= 1'b0;
            sb_start_q  <= 1'b0;
            sr_start_q  <= 1'b0;
            mc_start_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            ark_start_q <= (state_nx == ARK_ISSUE);
            sb_start_q  <= (state_nx == SB_ISSUE);
            sr_start_q  <= (state_nx == SR_ISSUE);
            mc_start_q  <= (state_nx == MC_ISSUE);
            busy_q      <= busy_nx_c;
            done_q      <= (state_q == ARK_WAIT) && (state_nx == DONE);
            error_q     <= (state_nx == ERR);
        end
    end

    // State register for the cipher block: plaintext on accept, unit result on capture.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_out_q <= '0;
        end else if (load_pt_c) begin
            state_out_q <= bus.plaintext;
        end else if (load_res_c) begin
            state_out_q <= result_c;
        end
    end

    // Round counter, advanced on each non-final ARK capture and saturating at 10.
    always_ff @(posedge clk) begin
        if (!rst) begin
            round_q <= '0;
        end else if (load_pt_c) begin
            round_q <= '0;
        end else if (round_inc_c && !last_round_c) begin
            round_q <= round_q + RND_W'(1);
        end
    end

    // Wait counter: cleared in ISSUE, counts WAIT cycles without finish.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (cnt_clr_c) begin
            cnt_q <= '0;
        end else if (cnt_inc_c) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.state_out   = state_out_q;
    assign bus.roundnumber = round_q;
    assign bus.ark_start   = ark_start_q;
    assign bus.sb_start    = sb_start_q;
    assign bus.sr_start    = sr_start_q;
    assign bus.mc_start    = mc_start_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.error       = error_q;

endmodule

// File: doc/aes_round_sequencer.md
AES_ROUND_SEQUENCER -- requirements
Module: aes_round_sequencer

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255, giving the maximum wait cycles for any unit finish before the block flags an error.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request one AES-128 encryption; sampled only in IDLE, DONE or ERR.
REQ-005 The block SHALL have port plaintext, input, 128 bits: block captured into the state register on an accepted start.
REQ-006 The block SHALL have port state_out, output, 128 bits: state register; feeds all step units and is the ciphertext when done=1.
REQ-007 The block SHALL have port roundnumber, output, 4 bits: current round 0..10, driven to addroundkey and held stable for the whole round.
REQ-008 The block SHALL have ports ark_start, sb_start, sr_start and mc_start, output, 1 bit each: single-cycle start pulses to addroundkey, subbytes, shiftrows and mixcolumns.
REQ-009 The block SHALL have ports ark_finish, sb_finish, sr_finish and mc_finish, input, 1 bit each: unit completion flags.
REQ-010 The block SHALL have ports ark_result, sb_result, sr_result and mc_result, input, 128 bits each: unit outputs.
REQ-011 The block SHALL have port busy, output, 1 bit: high from start acceptance until done or error.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle pulse when ciphertext is valid on state_out.
REQ-013 The block SHALL have port error, output, 1 bit: level, high in ERR.

Function
REQ-014 The step order SHALL be: round 0: ARK; rounds 1-9: SB, SR, MC, ARK; round 10: SB, SR, ARK; 40 steps total.
REQ-015 The FSM states SHALL be IDLE, SB, SR, MC, ARK, DONE and ERR, and each step state SHALL have an ISSUE phase and a WAIT phase.
REQ-016 When start=1 is sampled in IDLE, DONE or ERR, the block SHALL load plaintext into the state register, set roundnumber=0, busy=1 and error=0, and pulse ark_start in the next cycle.
REQ-017 The block SHALL hold each unit start high for exactly one cycle (ISSUE) and then enter WAIT.
REQ-018 In WAIT, only the active unit's finish SHALL be honoured; finish of other units and finish during ISSUE SHALL be ignored.
REQ-019 On the edge where the active finish=1 is sampled in WAIT, the block SHALL load that unit's result into the state register and enter ISSUE of the next step in the same edge, with no idle cycle.
REQ-020 roundnumber SHALL increment on the edge that captures the ARK result of rounds 0-9, and SHALL saturate at 10.
REQ-021 Capture of the round-10 ARK result SHALL go to DONE with done=1 for one cycle, busy=0, and state_out held until the next accepted start.
REQ-022 Latency: if every unit asserts finish exactly one cycle after its start pulse, each step SHALL take 2 cycles and done SHALL be high in the cycle after the 80th edge following the start-sampling edge.
REQ-023 The block SHALL ignore start while busy=1.
REQ-024 The wait counter SHALL reset on ISSUE and count cycles in WAIT; reaching TIMEOUT without finish SHALL enter ERR with error=1, busy=0, no done, roundnumber and state_out frozen, and all unit starts low.
REQ-025 Connected units SHALL clear finish on the edge on which they sample start, so that a stale finish is never seen in WAIT.
REQ-026 At most one unit start SHALL be high in any cycle.

Reset
REQ-027 With rst=0 sampled on an edge, the block SHALL force IDLE, with state_out=0, roundnumber=0, all unit starts=0, busy=0, done=0, error=0 and the wait counter at 0.
REQ-028 Reset SHALL take priority over start and finish, and an operation aborted by reset mid-round SHALL produce no done.

Verification
REQ-029 Reset: hold rst=0 for 2 cycles mid-encryption -> all outputs 0 the next cycle, no done, and IDLE accepts a new start.
REQ-030 FIPS-197 vector with 1-cycle behavioural units (key 2b7e151628aed2a6abf7158809cf4f3c, plaintext 3243f6a8885a308d313198a2e0370734) -> done at cycle 80 with state_out=3925841d02dc09fbdc118597196a0b32, and pulse counts ark=11, sb=10, sr=10, mc=9.
REQ-031 Ordering: log (start signal, roundnumber) per pulse -> exactly the REQ-014 sequence, roundnumber 0..10, and never two starts in one cycle.
REQ-032 Random unit latency of 1-5 cycles, same vector -> identical ciphertext, and done only after the round-10 ARK finish.
REQ-033 Timeout: mc_finish stuck at 0 in round 1, TIMEOUT=16 -> error=1 exactly 16 WAIT cycles after the mc_start pulse, busy=0, one mc_start only; a following start clears error and completes normally.
REQ-034 start pulsed repeatedly while busy, plus spurious sb_finish during ARK WAIT -> ignored, with ciphertext and 80-cycle latency unchanged.
